// File: rtl/fsk_symbol_sequencer_pkg.sv
// Shared types and constants for the FSK symbol sequencer.
// Provides the FSM state encoding, default widths and the symbol-length saturation helper.
package fsk_seq_pkg;

    localparam int unsigned TW_W_DEF  = 8;
    localparam int unsigned LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SYMBOL    = 2'd2
    } state_t;

    // A zero symbol length behaves as one clock per symbol.
    function automatic logic [31:0] len_sat(input logic [31:0] len);
        return (len == '0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/fsk_symbol_sequencer_if.sv
// Bit-source / accumulator-side bundle for fsk_symbol_sequencer.
// acc_clr exists only when FSK_SEQ_PHASE_CLR_EN is defined.
interface fsk_symbol_sequencer_if
    import fsk_seq_pkg::*;
#(
    parameter int unsigned TW_W  = TW_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
);
    logic              start;
    logic              abort;
    logic [TW_W-1:0]   mark_word;
    logic [TW_W-1:0]   space_word;
    logic [LEN_W-1:0]  sym_len;
    logic              data_valid;
    logic              data_bit;
    logic              data_last;
    logic              data_ready;
    logic [TW_W-1:0]   tw_out;
    logic              acc_en;
    logic              busy;
    logic              done;
    logic              underrun;
`ifdef FSK_SEQ_PHASE_CLR_EN
    logic              acc_clr;

    modport master (
        output start, abort, mark_word, space_word, sym_len,
        output data_valid, data_bit, data_last,
        input  data_ready, tw_out, acc_en, busy, done, underrun, acc_clr
    );

    modport slave (
        input  start, abort, mark_word, space_word, sym_len,
        input  data_valid, data_bit, data_last,
        output data_ready, tw_out, acc_en, busy, done, underrun, acc_clr
    );
`else
    modport master (
        output start, abort, mark_word, space_word, sym_len,
        output data_valid, data_bit, data_last,
        input  data_ready, tw_out, acc_en, busy, done, underrun
    );

    modport slave (
        input  start, abort, mark_word, space_word, sym_len,
        input  data_valid, data_bit, data_last,
        output data_ready, tw_out, acc_en, busy, done, underrun
    );
`endif
endinterface

// File: rtl/fsk_symbol_sequencer_timer.sv
// fsk_sym_timer: loadable down-counter that stops at zero (no wrap).
// Load takes priority over counting.
module fsk_sym_timer #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// FSK symbol sequencer: turns a valid/ready bit stream into mark/space tuning words held for sym_len clocks.
// Optional macro FSK_SEQ_PHASE_CLR_EN adds acc_clr, a phase-reset pulse on each tone change.
module fsk_symbol_sequencer
    import fsk_seq_pkg::*;
#(
    parameter int unsigned TW_W  = TW_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    fsk_symbol_sequencer_if.slave bus
);
    state_t            r_state;
    logic [TW_W-1:0]   r_mark;
    logic [TW_W-1:0]   r_space;
    logic [LEN_W-1:0]  r_len;
    logic [TW_W-1:0]   r_tw;
    logic              r_acc_en;
    logic              r_done;
    logic              r_underrun;
    logic              r_last;
`ifdef FSK_SEQ_PHASE_CLR_EN
    logic              r_clr;
    logic              r_prev_bit;
    logic              r_first;
`endif

    logic [LEN_W-1:0]  w_cnt;
    logic              w_zero;
    logic              w_ready;
    logic              w_accept;
    logic              w_load;
    logic [LEN_W-1:0]  w_load_val;
    logic              w_tmr_en;

    assign w_ready  = (r_state == WAIT_DATA) ||
                      ((r_state == SYMBOL) && (w_cnt == '0) && !r_last);
    assign w_accept = bus.data_valid && w_ready;

    // Abort parks the counter at zero; an accepted bit loads len-1 so each symbol spans len clocks.
    assign w_load     = bus.abort || w_accept;
    assign w_load_val = bus.abort ? '0 : (r_len - LEN_W'(1));
    assign w_tmr_en   = (r_state == SYMBOL);

    fsk_sym_timer #(
        .W (LEN_W)
    ) u_timer (
        .i_clk      (Clock),
        .i_rst      (Reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_tmr_en),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_mark     <= '0;
            r_space    <= '0;
            r_len      <= '0;
            r_tw       <= '0;
            r_acc_en   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_last     <= 1'b0;
`ifdef FSK_SEQ_PHASE_CLR_EN
            r_clr      <= 1'b0;
            r_prev_bit <= 1'b0;
            r_first    <= 1'b0;
`endif
        end else if (bus.abort) begin
            r_state  <= IDLE;
            r_tw     <= '0;
            r_acc_en <= 1'b0;
            r_done   <= 1'b0;
            r_last   <= 1'b0;
`ifdef FSK_SEQ_PHASE_CLR_EN
            r_clr    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef FSK_SEQ_PHASE_CLR_EN
            r_clr  <= 1'b0;
`endif
            // Accept is only possible in WAIT_DATA or at the end of a non-final symbol.
            if (w_accept) begin
                r_state  <= SYMBOL;
                r_tw     <= bus.data_bit ? r_mark : r_space;
                r_acc_en <= 1'b1;
                r_last   <= bus.data_last;
`ifdef FSK_SEQ_PHASE_CLR_EN
                r_clr      <= r_first || (bus.data_bit != r_prev_bit);
                r_prev_bit <= bus.data_bit;
                r_first    <= 1'b0;
`endif
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_tw     <= '0;
                        r_acc_en <= 1'b0;
                        if (bus.start) begin
                            r_mark     <= bus.mark_word;
                            r_space    <= bus.space_word;
                            r_len      <= LEN_W'(len_sat(32'(bus.sym_len)));
                            r_underrun <= 1'b0;
                            r_state    <= WAIT_DATA;
`ifdef FSK_SEQ_PHASE_CLR_EN
                            r_first    <= 1'b1;
`endif
                        end
                    end
                    WAIT_DATA: begin
                    end
                    SYMBOL: begin
                        if (w_zero) begin
                            if (r_last) begin
                                r_state  <= IDLE;
                                r_tw     <= '0;
                                r_acc_en <= 1'b0;
                                r_done   <= 1'b1;
                            end else begin
                                r_state    <= WAIT_DATA;
                                r_tw       <= r_space;
                                r_acc_en   <= 1'b1;
                                r_underrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.tw_out     = r_tw;
    assign bus.acc_en     = r_acc_en;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.underrun   = r_underrun;
`ifdef FSK_SEQ_PHASE_CLR_EN
    assign bus.acc_clr    = r_clr;
`endif

endmodule
